wb_burst_adr_gen: RTL and testbench
===================================

Name: wb_burst_adr_gen

Overview:
- Parametrised Wishbone burst address generator: next generation of the memory controller's 4-bit burst address incrementer.
- Captures a start address and burst type on init, then steps the address on each accepted beat. Supports linear, wrap-4, wrap-8 and wrap-16 bursts at any address width.
- Reports beats remaining, last-beat and done.
- Sits between the Wishbone slave front end and the SDRAM/SRAM FIFO read/write path.

Parameters:
- AW, 24, address width in words; 4 ≤ AW ≤ 32.
- LIN_LEN, 16, linear-burst line length in words; power of 2, 4..32. A linear burst ends at the next LIN_LEN-aligned boundary.
- INIT_DLY, 1:
  - 1: one LOAD cycle between init and first valid adr_o (memory read latency).
  - 0: capture directly into BURST.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- adr_i  in  AW  burst start word address
- cti_i  in  3  Wishbone cycle type identifier
- bte_i  in  2  Wishbone burst type extension
- init  in  1  start new burst, single-cycle pulse
- inc  in  1  beat accepted; advance address
- adr_o  out  AW  current beat address
- beats_left  out  6  beats remaining including the current one
- last  out  1  current beat is final beat
- busy  out  1  LOAD or BURST state
- done  out  1  burst complete; held until next init

Behaviour:
- Reset (rst=0, async): state=IDLE; adr_o=0, beats_left=0, last=0, busy=0, done=0; captured bte/cti=0.
- States: IDLE, LOAD, BURST, DONE.
- IDLE/DONE + init:
  - INIT_DLY=1: go to LOAD; done cleared in that cycle.
  - INIT_DLY=0: capture immediately, go to BURST.
- LOAD: unconditionally goes to BURST next cycle. Capture happens on the LOAD→BURST edge using adr_i/cti_i/bte_i sampled on the init cycle, which are registered at init.
- Capture:
  - adr_o ← adr_i.
  - Burst length N:
    - cti ∈ {000, 001, 111} → N=1.
    - cti=010, bte=01 → 4; bte=10 → 8; bte=11 → 16.
    - cti=010, bte=00 → N = LIN_LEN − (adr_i mod LIN_LEN).
    - Any other cti → N=1.
  - beats_left ← N.
- BURST:
  - busy=1.
  - last = (beats_left==1), combinational from the register.
  - inc with beats_left>1:
    - beats_left decrements.
    - adr_o advances per captured bte:
      - 01: low 2 bits +1 mod 4, upper bits held.
      - 10: low 3 bits mod 8.
      - 11: low 4 bits mod 16.
      - 00: full AW-bit +1, wrapping modulo 2^AW.
    - Single-beat bursts never advance.
  - inc with beats_left==1: beats_left←0, adr_o unchanged, state←DONE, done←1 next cycle, busy←0.
- inc outside BURST is ignored: no address or count change.
- init in BURST or LOAD aborts the current burst and restarts the capture sequence. done stays 0. Abort does not assert done.
- init and inc in the same cycle: init wins; inc is dropped.
- DONE holds adr_o, done=1 and beats_left=0 until the next init.
- Async reset mid-burst returns to IDLE immediately with all outputs at reset values.
- Latency:
  - INIT_DLY=1: init at cycle t → adr_o valid and busy=1 at t+2.
  - INIT_DLY=0: valid at t+1.
  - Each inc updates adr_o in the following cycle.

Test Plan:
- Reset, INIT_DLY=1: init with adr_i=0x000005, cti=010, bte=01; inc every cycle → adr_o sequence 5,6,7,4; beats_left 4,3,2,1; last only on 4; done=1 one cycle after 4th inc.
- Wrap-16: adr_i=0x00003E, bte=11, cti=010 → adr_o 3E,3F,30..3D (16 beats); upper bits stay 0x0003.
- Linear, LIN_LEN=16: adr_i=0x00001C, bte=00, cti=010 → N=4, adr_o 1C,1D,1E,1F, then done. With AW=4 and adr_i=0xE, LIN_LEN=4: adr_o E,F, done.
- Classic: cti=000 → beats_left=1, last=1 at capture; one inc → done=1, adr_o unchanged. Further inc → no change.
- Restart/simultaneous: wrap-8 burst stopped after 3 incs; then init+inc in the same cycle with adr_i=0x100 → new capture 0x100, beats_left=8, done never asserted.
- Reset mid-burst: rst=0 asynchronously during BURST → all outputs 0 immediately, state IDLE. inc after release → no change.

Source files
------------

// File: rtl/wb_burst_adr_gen_if.sv
// Wishbone burst address generator bus bundle: burst request inputs and beat status outputs.
interface wb_burst_adr_gen_if #(
   parameter int unsigned AW = 24
);
   logic [AW-1:0] adr_i;
   logic [2:0]    cti_i;
   logic [1:0]    bte_i;
   logic          init;
   logic          inc;
   logic [AW-1:0] adr_o;
   logic [5:0]    beats_left;
   logic          last;
   logic          busy;
   logic          done;

   // Generator side
   modport slave (
      input  adr_i, cti_i, bte_i, init, inc,
      output adr_o, beats_left, last, busy, done
   );

   // Front-end side
   modport master (
      output adr_i, cti_i, bte_i, init, inc,
      input  adr_o, beats_left, last, busy, done
   );
endinterface

// File: rtl/wb_burst_adr_gen.sv
// Wishbone burst address generator: captures a start address and burst type,
// then steps the beat address (linear or wrap-4/8/16) on each accepted beat.
module wb_burst_adr_gen #(
   parameter int unsigned AW       = 24,
   parameter int unsigned LIN_LEN  = 16,
   parameter int unsigned INIT_DLY = 1
) (
   input  logic              clk,
   input  logic              rst,
   wb_burst_adr_gen_if.slave bus
);

   localparam int unsigned BW = 6;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_BURST = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   adr_q, adr_d;
   logic [BW-1:0]   beats_q, beats_d;
   logic [1:0]      bte_q, bte_d;
   logic [AW-1:0]   ld_adr_q, ld_adr_d;
   logic [2:0]      ld_cti_q, ld_cti_d;
   logic [1:0]      ld_bte_q, ld_bte_d;
   logic [AW-1:0]   wrap_mask;
   logic [AW-1:0]   adr_step;

   // Beat count for a burst starting at address a
   function automatic logic [BW-1:0] burst_len(input logic [AW-1:0] a,
                                               input logic [2:0]    cti,
                                               input logic [1:0]    bte);
      logic [31:0] ext;
      ext = 32'(a);
      burst_len = BW'(1);
      if (cti == 3'b010) begin
         case (bte)
            2'b01:   burst_len = BW'(4);
            2'b10:   burst_len = BW'(8);
            2'b11:   burst_len = BW'(16);
            default: burst_len = BW'(32'(LIN_LEN) - (ext & 32'(LIN_LEN - 1)));
         endcase
      end
   endfunction

   // Next beat address: only the wrap field increments, upper bits held
   always_comb begin
      wrap_mask = '1;
      case (bte_q)
         2'b01:   wrap_mask = AW'(3);
         2'b10:   wrap_mask = AW'(7);
         2'b11:   wrap_mask = AW'(15);
         default: wrap_mask = '1;
      endcase
      adr_step = (adr_q & ~wrap_mask) | ((adr_q + AW'(1)) & wrap_mask);
   end

   // Next-state and datapath; init always wins over inc and aborts any burst
   always_comb begin
      state_d  = state_q;
      adr_d    = adr_q;
      beats_d  = beats_q;
      bte_d    = bte_q;
      ld_adr_d = ld_adr_q;
      ld_cti_d = ld_cti_q;
      ld_bte_d = ld_bte_q;
      if (bus.init) begin
         ld_adr_d = bus.adr_i;
         ld_cti_d = bus.cti_i;
         ld_bte_d = bus.bte_i;
         if (INIT_DLY != 0) begin
            state_d = S_LOAD;
         end else begin
            adr_d   = bus.adr_i;
            beats_d = burst_len(bus.adr_i, bus.cti_i, bus.bte_i);
            bte_d   = bus.bte_i;
            state_d = S_BURST;
         end
      end else begin
         case (state_q)
            S_LOAD: begin
               adr_d   = ld_adr_q;
               beats_d = burst_len(ld_adr_q, ld_cti_q, ld_bte_q);
               bte_d   = ld_bte_q;
               state_d = S_BURST;
            end
            S_BURST: begin
               if (bus.inc) begin
                  if (beats_q > BW'(1)) begin
                     beats_d = beats_q - BW'(1);
                     adr_d   = adr_step;
                  end else begin
                     beats_d = '0;
                     state_d = S_DONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         adr_q    <= '0;
         beats_q  <= '0;
         bte_q    <= '0;
         ld_adr_q <= '0;
         ld_cti_q <= '0;
         ld_bte_q <= '0;
      end else begin
         state_q  <= state_d;
         adr_q    <= adr_d;
         beats_q  <= beats_d;
         bte_q    <= bte_d;
         ld_adr_q <= ld_adr_d;
         ld_cti_q <= ld_cti_d;
         ld_bte_q <= ld_bte_d;
      end
   end

   assign bus.adr_o      = adr_q;
   assign bus.beats_left = beats_q;
   assign bus.last       = (state_q == S_BURST) && (beats_q == BW'(1));
   assign bus.busy       = (state_q == S_LOAD) || (state_q == S_BURST);
   assign bus.done       = (state_q == S_DONE);

endmodule

// File: tb/tb_wb_burst_adr_gen.sv
// Directed bench for wb_burst_adr_gen: INIT_DLY=1 at AW=24, INIT_DLY=0 at AW=4.
module tb_wb_burst_adr_gen;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   wb_burst_adr_gen_if #(.AW(24)) ifa ();
   wb_burst_adr_gen_if #(.AW(4))  ifb ();

   wb_burst_adr_gen #(.AW(24), .LIN_LEN(16), .INIT_DLY(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   wb_burst_adr_gen #(.AW(4), .LIN_LEN(4), .INIT_DLY(0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic [31:0] adr, input logic [31:0] beats,
                        input logic l, input logic b, input logic d);
      chk({tag, ".adr"},   32'(ifa.adr_o), adr);
      chk({tag, ".beats"}, 32'(ifa.beats_left), beats);
      chk({tag, ".last"},  32'(ifa.last), 32'(l));
      chk({tag, ".busy"},  32'(ifa.busy), 32'(b));
      chk({tag, ".done"},  32'(ifa.done), 32'(d));
   endtask

   task automatic chk_b(input string tag, input logic [31:0] adr, input logic [31:0] beats,
                        input logic l, input logic b, input logic d);
      chk({tag, ".adr"},   32'(ifb.adr_o), adr);
      chk({tag, ".beats"}, 32'(ifb.beats_left), beats);
      chk({tag, ".last"},  32'(ifb.last), 32'(l));
      chk({tag, ".busy"},  32'(ifb.busy), 32'(b));
      chk({tag, ".done"},  32'(ifb.done), 32'(d));
   endtask

   task automatic start_a(input logic [23:0] adr, input logic [2:0] cti, input logic [1:0] bte);
      ifa.adr_i = adr;
      ifa.cti_i = cti;
      ifa.bte_i = bte;
      ifa.init  = 1'b1;
      tick();
      ifa.init  = 1'b0;
   endtask

   initial begin
      ifa.adr_i = '0; ifa.cti_i = '0; ifa.bte_i = '0; ifa.init = 1'b0; ifa.inc = 1'b0;
      ifb.adr_i = '0; ifb.cti_i = '0; ifb.bte_i = '0; ifb.init = 1'b0; ifb.inc = 1'b0;

      // Reset state
      #12;
      chk_a("rst_a", 32'h0, 32'd0, 1'b0, 1'b0, 1'b0);
      chk_b("rst_b", 32'h0, 32'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();

      // Wrap-4 from 0x5 with one LOAD cycle
      start_a(24'h000005, 3'b010, 2'b01);
      chk("w4.load.busy", 32'(ifa.busy), 32'd1);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk_a($sformatf("w4.beat%0d", k), 32'h4 | ((32'h5 + 32'(k)) & 32'h3),
               32'(4 - k), (k == 3), 1'b1, 1'b0);
         ifa.inc = 1'b1;
         tick();
      end
      ifa.inc = 1'b0;
      chk_a("w4.done", 32'h4, 32'd0, 1'b0, 1'b0, 1'b1);

      // Wrap-16 from 0x3E keeps upper bits at 0x3
      start_a(24'h00003E, 3'b010, 2'b11);
      chk("w16.load.done", 32'(ifa.done), 32'd0);
      tick();
      for (int k = 0; k < 16; k++) begin
         chk_a($sformatf("w16.beat%0d", k), 32'h30 | ((32'hE + 32'(k)) & 32'hF),
               32'(16 - k), (k == 15), 1'b1, 1'b0);
         ifa.inc = 1'b1;
         tick();
      end
      ifa.inc = 1'b0;
      chk_a("w16.done", 32'h3D, 32'd0, 1'b0, 1'b0, 1'b1);

      // Linear from 0x1C ends at the 16-word boundary
      start_a(24'h00001C, 3'b010, 2'b00);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk_a($sformatf("lin.beat%0d", k), 32'h1C + 32'(k), 32'(4 - k), (k == 3), 1'b1, 1'b0);
         ifa.inc = 1'b1;
         tick();
      end
      ifa.inc = 1'b0;
      chk_a("lin.done", 32'h1F, 32'd0, 1'b0, 1'b0, 1'b1);

      // Classic single beat; extra inc in DONE ignored
      start_a(24'h123456, 3'b000, 2'b10);
      tick();
      chk_a("cls.cap", 32'h123456, 32'd1, 1'b1, 1'b1, 1'b0);
      ifa.inc = 1'b1;
      tick();
      chk_a("cls.done", 32'h123456, 32'd0, 1'b0, 1'b0, 1'b1);
      tick();
      ifa.inc = 1'b0;
      chk_a("cls.hold", 32'h123456, 32'd0, 1'b0, 1'b0, 1'b1);

      // Wrap-8 aborted after 3 beats by init+inc in the same cycle
      start_a(24'h000045, 3'b010, 2'b10);
      tick();
      ifa.inc = 1'b1;
      tick(); tick(); tick();
      ifa.inc = 1'b0;
      chk_a("w8.mid", 32'h40, 32'd5, 1'b0, 1'b1, 1'b0);
      ifa.inc = 1'b1;
      start_a(24'h000100, 3'b010, 2'b10);
      ifa.inc = 1'b0;
      chk("rs.load.done", 32'(ifa.done), 32'd0);
      chk("rs.load.busy", 32'(ifa.busy), 32'd1);
      tick();
      chk_a("rs.cap", 32'h100, 32'd8, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset mid-burst
      ifa.inc = 1'b1;
      tick();
      ifa.inc = 1'b0;
      chk_a("rs.beat1", 32'h101, 32'd7, 1'b0, 1'b1, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk_a("arst", 32'h0, 32'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      ifa.inc = 1'b1;
      tick();
      ifa.inc = 1'b0;
      chk_a("arst.inc", 32'h0, 32'd0, 1'b0, 1'b0, 1'b0);

      // AW=4, LIN_LEN=4, no LOAD cycle: linear from 0xE gives E,F
      ifb.adr_i = 4'hE;
      ifb.cti_i = 3'b010;
      ifb.bte_i = 2'b00;
      ifb.init  = 1'b1;
      tick();
      ifb.init  = 1'b0;
      chk_b("b.cap", 32'hE, 32'd2, 1'b0, 1'b1, 1'b0);
      ifb.inc = 1'b1;
      tick();
      chk_b("b.beat1", 32'hF, 32'd1, 1'b1, 1'b1, 1'b0);
      tick();
      ifb.inc = 1'b0;
      chk_b("b.done", 32'hF, 32'd0, 1'b0, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
